// File: rtl/alu_pkg.sv
// Shared definitions for the alu_sched scheduler.
// Contents: ALU opcodes, scheduler FSM states and the default datapath width.
package alu_pkg;

  localparam int XLEN_DEF = 64;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_MUL  = 4'd8,
    OP_MULH = 4'd9,
    OP_DIV  = 4'd10,
    OP_REM  = 4'd11,
    OP_SLT  = 4'd12,
    OP_SLTU = 4'd13
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  // mul/mulh/div/rem take the multicycle path through the ALU
  function automatic logic is_muldiv(input logic [3:0] op);
    return (op >= OP_MUL) && (op <= OP_REM);
  endfunction

endpackage

// File: rtl/alu_sched_if.sv
// Request/response channels of the two ALU requesters; index 0 is execute, index 1 is address/branch.
interface alu_sched_if #(
  parameter int XLEN = alu_pkg::XLEN_DEF
);
  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [1:0][XLEN-1:0] req_x;
  logic [1:0][XLEN-1:0] req_y;
  logic [1:0][3:0]      req_op;
  logic [1:0]           rsp_valid;
  logic [1:0]           rsp_ready;
  logic [1:0][XLEN-1:0] rsp_data;
  logic [1:0]           rsp_eq;

  modport master (
    output req_valid, req_x, req_y, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_eq
  );

  modport slave (
    input  req_valid, req_x, req_y, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_eq
  );
endinterface

// File: rtl/alu_sched_rr_arb2.sv
// Two-way round-robin grant: a lone valid wins, a tie goes to the requester not granted last.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_gnt_i,
  output logic [1:0] gnt_o
);

  assign gnt_o[0] = valid_i[0] & (~valid_i[1] |  last_gnt_i);
  assign gnt_o[1] = valid_i[1] & (~valid_i[0] | ~last_gnt_i);

endmodule

// File: rtl/alu_sched.sv
// Shares one external combinational ALU between two requesters, holding mul/div operands for MULDIV_LAT cycles.
// Optional macro ALU_SCHED_DIV0_EN: RISC-V divide/remainder-by-zero results generated locally in one cycle.
module alu_sched
  import alu_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int MULDIV_LAT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_sched_if.slave      bus,
  output logic [XLEN-1:0] alu_x_o,
  output logic [XLEN-1:0] alu_y_o,
  output logic [3:0]      alu_op_o,
  input  logic [XLEN-1:0] alu_out_i,
  input  logic            alu_eq_i,
  output logic            busy_o
);

  localparam int CW = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;

  state_e               state_q, state_d;
  logic [XLEN-1:0]      x_q, x_d, y_q, y_d;
  logic [3:0]           op_q, op_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 last_q, last_d;
  logic [1:0][XLEN-1:0] data_q, data_d;
  logic [1:0]           eq_q, eq_d;
  logic [1:0]           gnt;
  logic                 sel;
  logic [XLEN-1:0]      result;

  rr_arb2 u_arb (
    .valid_i    (bus.req_valid),
    .last_gnt_i (last_q),
    .gnt_o      (gnt)
  );

  assign sel = gnt[1];

`ifdef ALU_SCHED_DIV0_EN
  logic div0_in, div0_ex;
  assign div0_in = ((bus.req_op[sel] == OP_DIV) || (bus.req_op[sel] == OP_REM)) && (bus.req_y[sel] == '0);
  assign div0_ex = ((op_q == OP_DIV) || (op_q == OP_REM)) && (y_q == '0);
`endif

  always_comb begin
    // NOTE: every _d gets its hold value first, so no branch can leave a latch behind.
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    data_d  = data_q;
    eq_d    = eq_q;
    result  = '0;
    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          x_d    = bus.req_x[sel];
          y_d    = bus.req_y[sel];
          op_d   = bus.req_op[sel];
          last_d = sel;
          cnt_d  = is_muldiv(bus.req_op[sel]) ? CW'(MULDIV_LAT - 1) : '0;
`ifdef ALU_SCHED_DIV0_EN
          if (div0_in) cnt_d = '0;
`endif
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          // opcodes 14/15 have no defined ALU function; report zero
          result = (op_q >= 4'd14) ? '0 : alu_out_i;
`ifdef ALU_SCHED_DIV0_EN
          if (div0_ex) result = (op_q == OP_DIV) ? '1 : x_q;
`endif
          data_d[last_q] = result;
          eq_d[last_q]   = alu_eq_i;
          state_d        = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready[last_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments let every register sample pre-edge values regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      data_q  <= '0;
      eq_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      data_q  <= data_d;
      eq_q    <= eq_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE) ? gnt : 2'b00;
  assign bus.rsp_valid = (state_q == RESP) ? (last_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_eq    = eq_q;
  assign alu_x_o       = x_q;
  assign alu_y_o       = y_q;
  assign alu_op_o      = op_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched: behavioural ALU, randomized requests, monitor-side response checking.
module tb_alu_sched;
  import alu_pkg::*;

  localparam int XLEN = 64;
  localparam int LAT  = 4;

  typedef struct { logic [XLEN-1:0] x; logic [XLEN-1:0] y; logic [3:0] op; } req_t;
  typedef struct { logic [XLEN-1:0] data; logic eq; int lat; int acc; } exp_t;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;
  logic [XLEN-1:0] alu_x, alu_y, alu_out;
  logic [3:0]      alu_op;
  logic            alu_eq, busy;
  int              cyc   = 0;
  int              n_cmp = 0;
  int              n_bad = 0;

  req_t       plan[2][$];
  exp_t       sb[2][$];
  logic       last_model = 1'b1;
  int         issue_pct  = 100;
  logic       rsp_rand   = 1'b0;
  logic [1:0] rsp_force  = 2'b11;

  alu_sched_if #(.XLEN(XLEN)) bus ();

  alu_sched #(.XLEN(XLEN), .MULDIV_LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .alu_x_o   (alu_x),
    .alu_y_o   (alu_y),
    .alu_op_o  (alu_op),
    .alu_out_i (alu_out),
    .alu_eq_i  (alu_eq),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s @cyc %0d: event occurred, expected none", name, cyc);
  endtask

  // Behavioural RV64-style ALU standing in for the external unit
  function automatic logic [XLEN-1:0] alu_f(input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                                            input logic [3:0] op);
    logic signed [2*XLEN-1:0] p;
    logic [XLEN-1:0]          min_s;
    min_s = {1'b1, {(XLEN-1){1'b0}}};
    p = $signed({{XLEN{x[XLEN-1]}}, x}) * $signed({{XLEN{y[XLEN-1]}}, y});
    case (op)
      4'd0:  return x + y;
      4'd1:  return x - y;
      4'd2:  return x & y;
      4'd3:  return x | y;
      4'd4:  return x ^ y;
      4'd5:  return x << y[5:0];
      4'd6:  return x >> y[5:0];
      4'd7:  return XLEN'($signed(x) >>> y[5:0]);
      4'd8:  return x * y;
      4'd9:  return p[2*XLEN-1:XLEN];
      4'd10: begin
        if (y == '0) return '1;
        if (x == min_s && y == '1) return x;
        return XLEN'($signed(x) / $signed(y));
      end
      4'd11: begin
        if (y == '0) return x;
        if (x == min_s && y == '1) return '0;
        return XLEN'($signed(x) % $signed(y));
      end
      4'd12: return XLEN'($signed(x) < $signed(y));
      4'd13: return XLEN'(x < y);
      default: return 64'hA5A5_5A5A_DEAD_BEEF;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] ref_data(input req_t r);
    if (r.op >= 4'd14) return '0;
    return alu_f(r.x, r.y, r.op);
  endfunction

  function automatic int ref_lat(input req_t r);
`ifdef ALU_SCHED_DIV0_EN
    if ((r.op == 4'd10 || r.op == 4'd11) && r.y == '0) return 2;
`endif
    return (r.op >= 4'd8 && r.op <= 4'd11) ? LAT + 1 : 2;
  endfunction

  // The multicycle ALU yields garbage until its inputs have been stable for LAT cycles
  int                hold = 0;
  logic [2*XLEN+3:0] prev_in = '0;
  always @(negedge clk) begin
    if ({alu_x, alu_y, alu_op} == prev_in) hold <= hold + 1;
    else hold <= 1;
    prev_in <= {alu_x, alu_y, alu_op};
  end
  assign alu_out = (is_muldiv(alu_op) && hold < LAT) ? 64'hBAD0_BAD0_BAD0_BAD0 : alu_f(alu_x, alu_y, alu_op);
  assign alu_eq  = (alu_x == alu_y);

  initial begin : driver
    logic [1:0] acc;
    exp_t       e;
    acc           = '0;
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 2'b11;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.req_ready != 2'b00) begin
          check("gnt_onehot", XLEN'($countones(bus.req_ready)), XLEN'(1));
          if (bus.req_valid == 2'b11) check("rr_grant", XLEN'(bus.req_ready), XLEN'(last_model ? 2'b01 : 2'b10));
          else check("gnt_single", XLEN'(bus.req_ready), XLEN'(bus.req_valid));
        end else if (!busy && bus.req_valid != 2'b00) begin
          fail_now("no_grant_idle");
        end
        for (int n = 0; n < 2; n++) begin
          if (bus.req_valid[n] && bus.req_ready[n] && plan[n].size() > 0) begin
            e.data = ref_data(plan[n][0]);
            e.eq   = (plan[n][0].x == plan[n][0].y);
            e.lat  = ref_lat(plan[n][0]);
            e.acc  = cyc;
            sb[n].push_back(e);
            last_model = n[0];
            acc[n]     = 1'b1;
          end
        end
      end
      @(posedge clk);
      #1;
      if (!rst_n) begin
        plan[0].delete();
        plan[1].delete();
        acc           = '0;
        last_model    = 1'b1;
        bus.req_valid = '0;
      end else begin
        for (int n = 0; n < 2; n++) begin
          if (acc[n]) begin
            void'(plan[n].pop_front());
            bus.req_valid[n] = 1'b0;
            acc[n]           = 1'b0;
          end
          if (!bus.req_valid[n] && plan[n].size() > 0 && $urandom_range(0, 99) < issue_pct) begin
            bus.req_valid[n] = 1'b1;
            bus.req_x[n]     = plan[n][0].x;
            bus.req_y[n]     = plan[n][0].y;
            bus.req_op[n]    = plan[n][0].op;
          end
        end
      end
      bus.rsp_ready = rsp_rand ? 2'($urandom_range(0, 3)) : rsp_force;
    end
  end

  initial begin : monitor
    logic [1:0] seen;
    seen = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb[0].delete();
        sb[1].delete();
        seen = '0;
      end else begin
        for (int n = 0; n < 2; n++) begin
          if (bus.rsp_valid[n]) begin
            if (sb[n].size() == 0) begin
              fail_now("rsp_unexpected");
            end else begin
              if (!seen[n]) begin
                check("rsp_latency", XLEN'(cyc - sb[n][0].acc), XLEN'(sb[n][0].lat));
                seen[n] = 1'b1;
              end
              check("rsp_data", bus.rsp_data[n], sb[n][0].data);
              check("rsp_eq", XLEN'(bus.rsp_eq[n]), XLEN'(sb[n][0].eq));
              if (bus.rsp_ready[n]) begin
                void'(sb[n].pop_front());
                seen[n] = 1'b0;
              end
            end
          end
        end
      end
    end
  end

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while ((plan[0].size() > 0 || plan[1].size() > 0 || sb[0].size() > 0 || sb[1].size() > 0 || busy)
           && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (t >= budget) fail_now("drain_timeout");
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_alu_x"}, alu_x, '0);
    check({tag, "_alu_op"}, XLEN'(alu_op), '0);
    check({tag, "_busy"}, XLEN'(busy), '0);
    check({tag, "_rsp_valid"}, XLEN'(bus.rsp_valid), '0);
    check({tag, "_req_ready"}, XLEN'(bus.req_ready), '0);
    check({tag, "_rsp_data0"}, bus.rsp_data[0], '0);
    check({tag, "_rsp_data1"}, bus.rsp_data[1], '0);
    check({tag, "_rsp_eq"}, XLEN'(bus.rsp_eq), '0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    req_t r;
    int   t;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;

    plan[0].push_back('{x: 64'd5, y: 64'd7, op: OP_ADD});
    wait_drain(100);
    check("add_data", bus.rsp_data[0], 64'd12);
    check("add_eq", XLEN'(bus.rsp_eq[0]), '0);

    for (int i = 0; i < 4; i++) begin
      plan[0].push_back('{x: 64'd10, y: 64'd3, op: OP_SUB});
      plan[1].push_back('{x: 64'd4, y: 64'd4, op: OP_SUB});
    end
    wait_drain(200);
    check("rr_data0", bus.rsp_data[0], 64'd7);
    check("rr_data1", bus.rsp_data[1], 64'd0);
    check("rr_eq1", XLEN'(bus.rsp_eq[1]), XLEN'(1));

    plan[1].push_back('{x: 64'd100, y: 64'd7, op: OP_DIV});
    wait_drain(100);
    check("div_data", bus.rsp_data[1], 64'd14);

    rsp_force = 2'b10;
    plan[0].push_back('{x: 64'hF0, y: 64'hFF, op: OP_XOR});
    t = 0;
    while (!bus.rsp_valid[0] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) fail_now("bp_rsp_timeout");
    plan[1].push_back('{x: 64'd1, y: 64'd2, op: OP_ADD});
    repeat (6) begin
      @(negedge clk);
      check("bp_rsp_held", XLEN'(bus.rsp_valid[0]), XLEN'(1));
      check("bp_data", bus.rsp_data[0], 64'h0F);
      check("bp_req1_wait", XLEN'(bus.req_ready[1]), '0);
    end
    rsp_force = 2'b11;
    t = 0;
    while (!(bus.rsp_valid[0] && bus.rsp_ready[0]) && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) fail_now("bp_release_timeout");
    @(negedge clk);
    check("bp_grant_next", XLEN'(bus.req_ready[1]), XLEN'(1));
    wait_drain(100);

    plan[0].push_back('{x: 64'd3, y: 64'd5, op: OP_MUL});
    t = 0;
    while (!busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) fail_now("mul_start_timeout");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    plan[0].push_back('{x: 64'd11, y: 64'd22, op: OP_OR});
    plan[1].push_back('{x: 64'd33, y: 64'd44, op: OP_AND});
    t = 0;
    while (bus.req_ready == 2'b00 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("post_rst_gnt", XLEN'(bus.req_ready), XLEN'(2'b01));
    wait_drain(100);

`ifdef ALU_SCHED_DIV0_EN
    plan[0].push_back('{x: 64'd1234, y: 64'd0, op: OP_DIV});
    wait_drain(100);
    check("div0_data", bus.rsp_data[0], 64'hFFFF_FFFF_FFFF_FFFF);
    plan[0].push_back('{x: 64'd9, y: 64'd0, op: OP_REM});
    wait_drain(100);
    check("rem0_data", bus.rsp_data[0], 64'd9);
`endif

    rsp_rand  = 1'b1;
    issue_pct = 60;
    for (int i = 0; i < 300; i++) begin
      r.x  = {$urandom, $urandom};
      r.op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 7))
        0:       r.y = '0;
        1:       r.y = r.x;
        2:       r.y = XLEN'($urandom_range(0, 70));
        default: r.y = {$urandom, $urandom};
      endcase
      plan[i % 2].push_back(r);
    end
    wait_drain(20000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
